// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, opcodes,
// ALU function codes and datapath mux select codes.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_ADR  = 4'd11,
    S_JALR_PC   = 4'd12,
    S_LUI       = 4'd13
  } state_t;

  // Tells the ALU decoder how to interpret f3/f7 in the current state
  typedef enum logic [1:0] {
    CLS_ADD    = 2'd0,
    CLS_R      = 2'd1,
    CLS_I      = 2'd2,
    CLS_BRANCH = 2'd3
  } alu_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_SLTU = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_REG    = 2'd2;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RES_ALU_OUT = 2'd0;
  localparam logic [1:0] RES_MDR     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;
  localparam logic [1:0] RES_IMM     = 2'd3;

endpackage

// File: rtl/multi_cycle_controller_alu_control_decoder.sv
// Combinational ALU function selection from the state class and the
// funct3/funct7 fields latched in IR.
module alu_control_decoder
  import multi_cycle_controller_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  output logic [2:0]  alu_function
);

  always_comb begin
    alu_function = ALU_ADD;
    case (alu_class)
      // Any funct7 other than the two legal encodings falls back to ADD
      CLS_R: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  alu_function = ALU_ADD;
            3'b111:  alu_function = ALU_AND;
            3'b110:  alu_function = ALU_OR;
            3'b010:  alu_function = ALU_SLT;
            3'b011:  alu_function = ALU_SLTU;
            default: alu_function = ALU_ADD;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          alu_function = ALU_SUB;
        end
      end
      CLS_I: begin
        case (f3)
          3'b000:  alu_function = ALU_ADD;
          3'b100:  alu_function = ALU_XOR;
          3'b110:  alu_function = ALU_OR;
          3'b010:  alu_function = ALU_SLT;
          3'b011:  alu_function = ALU_SLTU;
          default: alu_function = ALU_ADD;
        endcase
      end
      CLS_BRANCH: begin
        case (f3)
          3'b000, 3'b001: alu_function = ALU_SUB;
          3'b100, 3'b101: alu_function = ALU_SLT;
          default:        alu_function = ALU_ADD;
        endcase
      end
      default: alu_function = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main sequencing FSM for the multi-cycle RV32I datapath: Moore outputs from
// the registered state, except the branch PC write which also follows zero.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       old_pc_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_function,
  output logic [1:0] result_src
);

  logic [STATE_W-1:0] state_reg;
  state_t             state;
  state_t             next_state;
  alu_class_t         alu_class;
  logic               branch_taken;

  assign state = state_t'(state_reg);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= STATE_W'(S_FETCH);
    else       state_reg <= STATE_W'(next_state);
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR_ADR;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_FETCH;
        endcase
      end
      S_MEM_ADR:  next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: next_state = S_MEM_WB;
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR_PC: next_state = S_ALU_WB;
      S_JALR_ADR: next_state = S_JALR_PC;
      default:    next_state = S_FETCH;
    endcase
  end

  // blt/bge use SLT, so zero means "not less than"
  always_comb begin
    case (f3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = !zero;
      3'b101:  branch_taken = zero;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    old_pc_write = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    imm_src      = IMM_I;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_REG;
    result_src   = RES_ALU_OUT;
    alu_class    = CLS_ADD;
    case (state)
      S_FETCH: begin
        ir_write     = 1'b1;
        old_pc_write = 1'b1;
        pc_write     = 1'b1;
        alu_src_b    = SRC_B_FOUR;
        result_src   = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_READ: adr_src = 1'b1;
      S_MEM_WB: begin
        result_src = RES_MDR;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_REG;
        alu_class = CLS_R;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        alu_class = CLS_I;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRC_A_REG;
        alu_class = CLS_BRANCH;
        pc_write  = branch_taken;
      end
      S_JAL, S_JALR_PC: begin
        pc_write  = 1'b1;
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
      end
      S_JALR_ADR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
    // Suppress every architectural write while reset is held
    if (reset) begin
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      old_pc_write = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
    end
  end

  alu_control_decoder u_alu_control_decoder (
    .alu_class    (alu_class),
    .f3           (f3),
    .f7           (f7),
    .alu_function (alu_function)
  );

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: per-cycle expected control
// words are queued by the stimulus process and checked by a monitor.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       old_pc_write;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_function;
    logic [1:0] result_src;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic [6:0] f7 = 7'd0;
  logic       zero = 1'b0;
  logic       adr_src, mem_write, ir_write, old_pc_write, pc_write, reg_write;
  logic [2:0] imm_src, alu_function;
  logic [1:0] alu_src_a, alu_src_b, result_src;

  ctrl_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  multi_cycle_controller dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .f3           (f3),
    .f7           (f7),
    .zero         (zero),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .old_pc_write (old_pc_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .imm_src      (imm_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_function (alu_function),
    .result_src   (result_src)
  );

  always #5 clk = ~clk;

  // Field order: adr mem_wr ir_wr oldpc_wr pc_wr reg_wr imm a b func res
  function automatic ctrl_t mk(input logic adr, input logic mw, input logic irw,
                               input logic opw, input logic pcw, input logic rw,
                               input logic [2:0] imm, input logic [1:0] a,
                               input logic [1:0] b, input logic [2:0] fn,
                               input logic [1:0] rs);
    ctrl_t c;
    c = '{adr, mw, irw, opw, pcw, rw, imm, a, b, fn, rs};
    return c;
  endfunction

  ctrl_t E_FETCH, E_FETCH_RST, E_DEC_B, E_DEC_J, E_ADD, E_SUB, E_XORI, E_ALU_WB;
  ctrl_t E_LW_ADR, E_SW_ADR, E_MEM_READ, E_MEM_WB, E_MEM_WRITE;
  ctrl_t E_BEQ_T, E_BEQ_N, E_BLT_T, E_BGE_N, E_JAL, E_JALR_ADR, E_JALR_PC, E_LUI, E_IDLE;

  initial begin
    E_FETCH     = mk(0,0,1,1,1,0, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2);
    E_FETCH_RST = mk(0,0,0,0,0,0, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2);
    E_DEC_B     = mk(0,0,0,0,0,0, 3'd2, 2'd1, 2'd1, 3'd0, 2'd0);
    E_DEC_J     = mk(0,0,0,0,0,0, 3'd3, 2'd1, 2'd1, 3'd0, 2'd0);
    E_ADD       = mk(0,0,0,0,0,0, 3'd0, 2'd2, 2'd0, 3'd0, 2'd0);
    E_SUB       = mk(0,0,0,0,0,0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0);
    E_XORI      = mk(0,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 3'd6, 2'd0);
    E_ALU_WB    = mk(0,0,0,0,0,1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0);
    E_IDLE      = mk(0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0);
    E_LW_ADR    = mk(0,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0);
    E_SW_ADR    = mk(0,0,0,0,0,0, 3'd1, 2'd2, 2'd1, 3'd0, 2'd0);
    E_MEM_READ  = mk(1,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0);
    E_MEM_WB    = mk(0,0,0,0,0,1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd1);
    E_MEM_WRITE = mk(1,1,0,0,0,0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0);
    E_BEQ_T     = mk(0,0,0,0,1,0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0);
    E_BEQ_N     = mk(0,0,0,0,0,0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0);
    E_BLT_T     = mk(0,0,0,0,1,0, 3'd0, 2'd2, 2'd0, 3'd4, 2'd0);
    E_BGE_N     = mk(0,0,0,0,0,0, 3'd0, 2'd2, 2'd0, 3'd4, 2'd0);
    E_JAL       = mk(0,0,0,0,1,0, 3'd0, 2'd1, 2'd2, 3'd0, 2'd0);
    E_JALR_ADR  = mk(0,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0);
    E_JALR_PC   = mk(0,0,0,0,1,0, 3'd0, 2'd1, 2'd2, 3'd0, 2'd0);
    E_LUI       = mk(0,0,0,0,0,1, 3'd4, 2'd0, 2'd0, 3'd0, 2'd3);
  end

  // Drive one cycle of inputs, queue the expected control word, advance a cycle
  task automatic applyStimulus(input string nm, input logic rst, input logic [6:0] op,
                               input logic [2:0] fn3, input logic [6:0] fn7,
                               input logic z, input ctrl_t e);
    reset  = rst;
    opcode = op;
    f3     = fn3;
    f7     = fn7;
    zero   = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input ctrl_t e);
    ctrl_t act;
    act = '{adr_src, mem_write, ir_write, old_pc_write, pc_write, reg_write,
            imm_src, alu_src_a, alu_src_b, alu_function, result_src};
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL %s: got %b_%b_%b_%b_%b_%b imm=%0d a=%0d b=%0d fn=%0d res=%0d, expected %b_%b_%b_%b_%b_%b imm=%0d a=%0d b=%0d fn=%0d res=%0d",
               nm, act.adr_src, act.mem_write, act.ir_write, act.old_pc_write, act.pc_write,
               act.reg_write, act.imm_src, act.alu_src_a, act.alu_src_b, act.alu_function,
               act.result_src, e.adr_src, e.mem_write, e.ir_write, e.old_pc_write, e.pc_write,
               e.reg_write, e.imm_src, e.alu_src_a, e.alu_src_b, e.alu_function, e.result_src);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(name_q.pop_front(), exp_q.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // add then sub
    applyStimulus("add_fetch",  0, 7'b0110011, 3'b000, 7'b0000000, 0, E_FETCH);
    applyStimulus("add_decode", 0, 7'b0110011, 3'b000, 7'b0000000, 0, E_DEC_B);
    applyStimulus("add_exec",   0, 7'b0110011, 3'b000, 7'b0000000, 0, E_ADD);
    applyStimulus("add_wb",     0, 7'b0110011, 3'b000, 7'b0000000, 0, E_ALU_WB);
    applyStimulus("sub_fetch",  0, 7'b0110011, 3'b000, 7'b0100000, 0, E_FETCH);
    applyStimulus("sub_decode", 0, 7'b0110011, 3'b000, 7'b0100000, 0, E_DEC_B);
    applyStimulus("sub_exec",   0, 7'b0110011, 3'b000, 7'b0100000, 0, E_SUB);
    applyStimulus("sub_wb",     0, 7'b0110011, 3'b000, 7'b0100000, 0, E_ALU_WB);
    // reset held two cycles starting in EXEC_R
    applyStimulus("rst_fetch",  0, 7'b0110011, 3'b000, 7'b0000000, 0, E_FETCH);
    applyStimulus("rst_decode", 0, 7'b0110011, 3'b000, 7'b0000000, 0, E_DEC_B);
    applyStimulus("rst_exec",   1, 7'b0110011, 3'b000, 7'b0000000, 0, E_ADD);
    applyStimulus("rst_fetch2", 1, 7'b0110011, 3'b000, 7'b0000000, 0, E_FETCH_RST);
    // reset landing in ALU_WB must block reg_write
    applyStimulus("wbr_fetch",  0, 7'b0110011, 3'b000, 7'b0000000, 0, E_FETCH);
    applyStimulus("wbr_decode", 0, 7'b0110011, 3'b000, 7'b0000000, 0, E_DEC_B);
    applyStimulus("wbr_exec",   0, 7'b0110011, 3'b000, 7'b0000000, 0, E_ADD);
    applyStimulus("wbr_wb_rst", 1, 7'b0110011, 3'b000, 7'b0000000, 0, E_IDLE);
    // xori
    applyStimulus("xori_fetch",  0, 7'b0010011, 3'b100, 7'b0100000, 0, E_FETCH);
    applyStimulus("xori_decode", 0, 7'b0010011, 3'b100, 7'b0100000, 0, E_DEC_B);
    applyStimulus("xori_exec",   0, 7'b0010011, 3'b100, 7'b0100000, 0, E_XORI);
    applyStimulus("xori_wb",     0, 7'b0010011, 3'b100, 7'b0100000, 0, E_ALU_WB);
    // lw / sw
    applyStimulus("lw_fetch",   0, 7'b0000011, 3'b010, 7'b0000000, 0, E_FETCH);
    applyStimulus("lw_decode",  0, 7'b0000011, 3'b010, 7'b0000000, 0, E_DEC_B);
    applyStimulus("lw_adr",     0, 7'b0000011, 3'b010, 7'b0000000, 0, E_LW_ADR);
    applyStimulus("lw_read",    0, 7'b0000011, 3'b010, 7'b0000000, 0, E_MEM_READ);
    applyStimulus("lw_wb",      0, 7'b0000011, 3'b010, 7'b0000000, 0, E_MEM_WB);
    applyStimulus("sw_fetch",   0, 7'b0100011, 3'b010, 7'b0000000, 0, E_FETCH);
    applyStimulus("sw_decode",  0, 7'b0100011, 3'b010, 7'b0000000, 0, E_DEC_B);
    applyStimulus("sw_adr",     0, 7'b0100011, 3'b010, 7'b0000000, 0, E_SW_ADR);
    applyStimulus("sw_write",   0, 7'b0100011, 3'b010, 7'b0000000, 0, E_MEM_WRITE);
    // branches
    applyStimulus("beqt_fetch",  0, 7'b1100011, 3'b000, 7'b0000000, 1, E_FETCH);
    applyStimulus("beqt_decode", 0, 7'b1100011, 3'b000, 7'b0000000, 1, E_DEC_B);
    applyStimulus("beqt_branch", 0, 7'b1100011, 3'b000, 7'b0000000, 1, E_BEQ_T);
    applyStimulus("beqn_fetch",  0, 7'b1100011, 3'b000, 7'b0000000, 0, E_FETCH);
    applyStimulus("beqn_decode", 0, 7'b1100011, 3'b000, 7'b0000000, 0, E_DEC_B);
    applyStimulus("beqn_branch", 0, 7'b1100011, 3'b000, 7'b0000000, 0, E_BEQ_N);
    applyStimulus("blt_fetch",   0, 7'b1100011, 3'b100, 7'b0000000, 0, E_FETCH);
    applyStimulus("blt_decode",  0, 7'b1100011, 3'b100, 7'b0000000, 0, E_DEC_B);
    applyStimulus("blt_branch",  0, 7'b1100011, 3'b100, 7'b0000000, 0, E_BLT_T);
    applyStimulus("bge_fetch",   0, 7'b1100011, 3'b101, 7'b0000000, 0, E_FETCH);
    applyStimulus("bge_decode",  0, 7'b1100011, 3'b101, 7'b0000000, 0, E_DEC_B);
    applyStimulus("bge_branch",  0, 7'b1100011, 3'b101, 7'b0000000, 0, E_BGE_N);
    // jal / jalr
    applyStimulus("jal_fetch",   0, 7'b1101111, 3'b000, 7'b0000000, 0, E_FETCH);
    applyStimulus("jal_decode",  0, 7'b1101111, 3'b000, 7'b0000000, 0, E_DEC_J);
    applyStimulus("jal_jal",     0, 7'b1101111, 3'b000, 7'b0000000, 0, E_JAL);
    applyStimulus("jal_wb",      0, 7'b1101111, 3'b000, 7'b0000000, 0, E_ALU_WB);
    applyStimulus("jalr_fetch",  0, 7'b1100111, 3'b000, 7'b0000000, 0, E_FETCH);
    applyStimulus("jalr_decode", 0, 7'b1100111, 3'b000, 7'b0000000, 0, E_DEC_B);
    applyStimulus("jalr_adr",    0, 7'b1100111, 3'b000, 7'b0000000, 0, E_JALR_ADR);
    applyStimulus("jalr_pc",     0, 7'b1100111, 3'b000, 7'b0000000, 0, E_JALR_PC);
    applyStimulus("jalr_wb",     0, 7'b1100111, 3'b000, 7'b0000000, 0, E_ALU_WB);
    // lui, then an unsupported opcode that must return straight to FETCH
    applyStimulus("lui_fetch",   0, 7'b0110111, 3'b000, 7'b0000000, 0, E_FETCH);
    applyStimulus("lui_decode",  0, 7'b0110111, 3'b000, 7'b0000000, 0, E_DEC_B);
    applyStimulus("lui_lui",     0, 7'b0110111, 3'b000, 7'b0000000, 0, E_LUI);
    applyStimulus("nop_fetch",   0, 7'b1111111, 3'b000, 7'b0000000, 0, E_FETCH);
    applyStimulus("nop_decode",  0, 7'b1111111, 3'b000, 7'b0000000, 0, E_DEC_B);
    applyStimulus("nop_refetch", 0, 7'b1111111, 3'b000, 7'b0000000, 0, E_FETCH);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d entries left in scoreboard, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
